// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - two-requester issue controller for the shared 16-bit ALU
//
// Purpose: round-robin arbitrates requester 0 (instruction datapath) and requester 1
// (compare/branch unit) onto one combinational ALU, one operation in flight at a time.
// Registers the ALU operands/opcode, owns the {N,Z,F,L,C} flag register and returns the
// result on a valid/ready response channel.
// Optional feature macro: ALU_CTRL_ADDC_EN enables the two-pass ADDC (0x07) sequence.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b (N=0,1) request channels, accepted on valid & ready
//   alu_r1, alu_r2, alu_opcode      registered ALU inputs
//   alu_rout                        ALU result (combinational)
//   rsp_valid/ready/id/data/err     response channel, held until rsp_ready
//   flags                           architectural flags {N,Z,F,L,C}

module alu_issue_ctrl #(
    parameter int         DATA_W   = 16,
    parameter bit         RR_INIT  = 1'b0,
    parameter logic [4:0] FLAG_RST = 5'b00000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [7:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [7:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [DATA_W-1:0] alu_r1,
    output logic [DATA_W-1:0] alu_r2,
    output logic [7:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_rout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [4:0]        flags
);

    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDU = 8'h06;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam int         MSB     = DATA_W - 1;

`ifdef ALU_CTRL_ADDC_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_EXEC2, S_RESP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
`endif

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic [DATA_W-1:0]   r1_q, r1_d, r2_q, r2_d;
    logic [7:0]          op_q, op_d;
    logic                id_q, id_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic [4:0]          flags_q, flags_d;
`ifdef ALU_CTRL_ADDC_EN
    // First-pass carry and original operand signs, needed to finish ADDC flags in EXEC2.
    logic                c1_q, c1_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
`endif

    logic                gnt_valid, gnt_id;
    logic [1:0]          req_valid;
    logic [7:0]          gnt_op;
    logic [DATA_W-1:0]   gnt_a, gnt_b;

    // Carry out of the top bit, recovered from the operand sign bits and the result sign bit:
    // carry-in to the MSB is a^b^res, so carry = a&b | (a^b)&~res.
    function automatic logic msb_carry(input logic a, input logic b, input logic r);
        return (a & b) | ((a ^ b) & ~r);
    endfunction

    function automatic logic op_supported(input logic [7:0] op);
        case (op)
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08,
            8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84: return 1'b1;
`ifdef ALU_CTRL_ADDC_EN
            8'h07:                              return 1'b1;
`endif
            default:                            return 1'b0;
        endcase
    endfunction

    assign req_valid = {req1_valid, req0_valid};

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = prio_q;
        if (req_valid[prio_q]) begin
            gnt_valid = 1'b1;
            gnt_id    = prio_q;
        end else if (req_valid[~prio_q]) begin
            gnt_valid = 1'b1;
            gnt_id    = ~prio_q;
        end
    end

    assign gnt_op = gnt_id ? req1_op : req0_op;
    assign gnt_a  = gnt_id ? req1_a  : req0_a;
    assign gnt_b  = gnt_id ? req1_b  : req0_b;

    // rst_n gating keeps ready low while reset is held even if a requester is valid.
    assign req0_ready = rst_n && (state_q == S_IDLE) && gnt_valid && !gnt_id;
    assign req1_ready = rst_n && (state_q == S_IDLE) && gnt_valid && gnt_id;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        op_d    = op_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
        flags_d = flags_q;
`ifdef ALU_CTRL_ADDC_EN
        c1_d    = c1_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_valid) begin
                    r1_d   = gnt_a;
                    r2_d   = gnt_b;
                    op_d   = gnt_op;
                    id_d   = gnt_id;
                    prio_d = ~gnt_id;
                    if (op_supported(gnt_op)) begin
                        err_d   = 1'b0;
                        state_d = S_EXEC;
                    end else begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                data_d  = alu_rout;
                state_d = S_RESP;
                case (op_q)
                    OP_ADD: flags_d = {2'b00,
                        (r1_q[MSB] == r2_q[MSB]) && (alu_rout[MSB] != r1_q[MSB]), 1'b0,
                        msb_carry(r1_q[MSB], r2_q[MSB], alu_rout[MSB])};
                    OP_SUB: flags_d = {2'b00,
                        (r1_q[MSB] != r2_q[MSB]) && (alu_rout[MSB] != r1_q[MSB]), 1'b0,
                        msb_carry(r1_q[MSB], ~r2_q[MSB], alu_rout[MSB])};
                    OP_CMP: flags_d = {$signed(r1_q) < $signed(r2_q), r1_q == r2_q, 1'b0,
                        r1_q < r2_q, 1'b0};
`ifdef ALU_CTRL_ADDC_EN
                    OP_ADDC: begin
                        // Second pass adds the pre-op carry to the first-pass sum.
                        c1_d    = msb_carry(r1_q[MSB], r2_q[MSB], alu_rout[MSB]);
                        a_msb_d = r1_q[MSB];
                        b_msb_d = r2_q[MSB];
                        r1_d    = alu_rout;
                        r2_d    = {{(DATA_W-1){1'b0}}, flags_q[0]};
                        op_d    = OP_ADDU;
                        state_d = S_EXEC2;
                    end
`endif
                    default: ;
                endcase
            end
`ifdef ALU_CTRL_ADDC_EN
            S_EXEC2: begin
                data_d  = alu_rout;
                flags_d = {2'b00,
                    (a_msb_q == b_msb_q) && (alu_rout[MSB] != a_msb_q), 1'b0,
                    c1_q | msb_carry(r1_q[MSB], 1'b0, alu_rout[MSB])};
                state_d = S_RESP;
            end
`endif
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            prio_q  <= RR_INIT;
            r1_q    <= '0;
            r2_q    <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            flags_q <= FLAG_RST;
`ifdef ALU_CTRL_ADDC_EN
            c1_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            op_q    <= op_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
            flags_q <= flags_d;
`ifdef ALU_CTRL_ADDC_EN
            c1_q    <= c1_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
`endif
        end
    end

    assign alu_r1     = r1_q;
    assign alu_r2     = r2_q;
    assign alu_opcode = op_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = id_q;
    assign rsp_data   = data_q;
    assign rsp_err    = err_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl

module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0]  req0_op, req1_op, alu_opcode;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [15:0] alu_r1, alu_r2, alu_rout, rsp_data;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [4:0]  flags;

    int n_chk  = 0;
    int n_pass = 0;
    logic [4:0] exp_flags;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_opcode(alu_opcode), .alu_rout(alu_rout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .flags(flags)
    );

    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        case (alu_opcode)
            8'h01:               alu_rout = alu_r1 & alu_r2;
            8'h02:               alu_rout = alu_r1 | alu_r2;
            8'h03:               alu_rout = alu_r1 ^ alu_r2;
            8'h04:               alu_rout = ~alu_r1;
            8'h05, 8'h06, 8'h07: alu_rout = alu_r1 + alu_r2;
            8'h08:               alu_rout = alu_r1 >> alu_r2[3:0];
            8'h09, 8'h0B:        alu_rout = alu_r1 - alu_r2;
            8'h0C, 8'h84:        alu_rout = alu_r1 << alu_r2[3:0];
            8'h0F:               alu_rout = $signed(alu_r1) >>> alu_r2[3:0];
            default:             alu_rout = 16'h0000;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_req(input int id, input logic v, input logic [7:0] op,
                             input logic [15:0] a, input logic [15:0] b);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Returns #1 after the accepting clock edge.
    task automatic wait_accept(input int id);
        int n = 0;
        logic rdy;
        forever begin
            @(negedge clk);
            rdy = (id == 0) ? req0_ready : req1_ready;
            if (rdy) break;
            n++;
            if (n > 20) begin
                n_chk++;
                $display("FAIL accept_timeout: requester %0d never ready", id);
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    // Counts negedges after acceptance until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
            if (lat > 10) begin
                n_chk++;
                $display("FAIL rsp_timeout: rsp_valid never rose");
                return;
            end
        end
    endtask

    task automatic run_op(input string tag, input int id, input logic [7:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] e_data, input logic e_err,
                          input int e_lat, input logic [4:0] e_flags);
        int lat;
        drive_req(id, 1'b1, op, a, b);
        wait_accept(id);
        drive_req(id, 1'b0, 8'h00, 16'h0, 16'h0);
        wait_rsp(lat);
        chk({tag, "_lat"},   lat,      e_lat);
        chk({tag, "_data"},  rsp_data, e_data);
        chk({tag, "_id"},    rsp_id,   id);
        chk({tag, "_err"},   rsp_err,  e_err);
        chk({tag, "_flags"}, flags,    e_flags);
        @(posedge clk); #1;
        chk({tag, "_onecyc"}, rsp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive_req(0, 1'b0, 8'h00, 16'h0, 16'h0);
        drive_req(1, 1'b0, 8'h00, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_ready0",    req0_ready, 1'b0);
        chk("rst_ready1",    req1_ready, 1'b0);
        chk("rst_flags",     flags, 5'b00000);
        chk("rst_alu_r1",    alu_r1, 16'h0);
        chk("rst_alu_op",    alu_opcode, 8'h00);
        chk("rst_rsp_data",  rsp_data, 16'h0);
        chk("rst_rsp_err",   rsp_err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Both requesters valid right after reset: requester 0 has priority.
        drive_req(0, 1'b1, 8'h01, 16'hFF00, 16'h0FF0);
        drive_req(1, 1'b1, 8'h02, 16'hFF00, 16'h0FF0);
        @(negedge clk);
        chk("rr_ready0", req0_ready, 1'b1);
        chk("rr_ready1", req1_ready, 1'b0);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 8'h00, 16'h0, 16'h0);
        wait_rsp(lat);
        chk("rr_lat0",       lat, 2);
        chk("rr_data0",      rsp_data, 16'h0F00);
        chk("rr_id0",        rsp_id, 1'b0);
        chk("rr_busy_ready1", req1_ready, 1'b0);
        @(posedge clk); #1;
        wait_accept(1);
        drive_req(1, 1'b0, 8'h00, 16'h0, 16'h0);
        wait_rsp(lat);
        chk("rr_lat1",  lat, 2);
        chk("rr_data1", rsp_data, 16'hFFF0);
        chk("rr_id1",   rsp_id, 1'b1);
        chk("rr_flags", flags, 5'b00000);
        @(posedge clk); #1;

        // Flags encoded as {N,Z,F,L,C}.
        run_op("add_ovf", 0, 8'h05, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 2, 5'b00100);
        run_op("cmp_neg", 1, 8'h0B, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 2, 5'b10000);
        run_op("cmp_eq",  1, 8'h0B, 16'h0005, 16'h0005, 16'h0000, 1'b0, 2, 5'b01000);
        run_op("add_cy",  0, 8'h05, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 2, 5'b00001);
`ifdef ALU_CTRL_ADDC_EN
        run_op("addc",    0, 8'h07, 16'h0001, 16'h0001, 16'h0003, 1'b0, 3, 5'b00000);
        exp_flags = 5'b00000;
`else
        run_op("addc",    0, 8'h07, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1, 5'b00001);
        exp_flags = 5'b00001;
`endif
        run_op("xor_nofl", 1, 8'h03, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 2, exp_flags);

        // Unsupported opcode with back-pressure; requester 1 waits meanwhile.
        rsp_ready = 1'b0;
        drive_req(0, 1'b1, 8'h0A, 16'h1234, 16'h5678);
        wait_accept(0);
        drive_req(0, 1'b0, 8'h00, 16'h0, 16'h0);
        drive_req(1, 1'b1, 8'h04, 16'h00FF, 16'h0000);
        wait_rsp(lat);
        chk("bad_lat",   lat, 1);
        chk("bad_err",   rsp_err, 1'b1);
        chk("bad_data",  rsp_data, 16'h0);
        chk("bad_flags", flags, exp_flags);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_valid",  rsp_valid, 1'b1);
            chk("stall_data",   rsp_data, 16'h0);
            chk("stall_err",    rsp_err, 1'b1);
            chk("stall_ready1", req1_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        wait_accept(1);
        drive_req(1, 1'b0, 8'h00, 16'h0, 16'h0);
        wait_rsp(lat);
        chk("not_lat",   lat, 2);
        chk("not_data",  rsp_data, 16'hFF00);
        chk("not_id",    rsp_id, 1'b1);
        chk("not_err",   rsp_err, 1'b0);
        chk("not_flags", flags, exp_flags);
        @(posedge clk); #1;

        // Reset during EXEC of a carry-producing SUB.
        drive_req(0, 1'b1, 8'h09, 16'h0005, 16'h0003);
        wait_accept(0);
        drive_req(0, 1'b0, 8'h00, 16'h0, 16'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", flags, 5'b00000);
        chk("mid_rst_valid", rsp_valid, 1'b0);
        drive_req(0, 1'b1, 8'h05, 16'h0002, 16'h0003);
        @(negedge clk);
        chk("mid_rst_ready0", req0_ready, 1'b0);
        chk("mid_rst_valid2", rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready0", req0_ready, 1'b1);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 8'h00, 16'h0, 16'h0);
        chk("post_rst_novalid", rsp_valid, 1'b0);
        wait_rsp(lat);
        chk("post_rst_lat",   lat, 2);
        chk("post_rst_data",  rsp_data, 16'h0005);
        chk("post_rst_flags", flags, 5'b00000);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
